// File: rtl/uart_tx_from_buf_pkg.sv
// Shared constants and types for the ring-buffer-fed UART transmitter.
package uart_tx_from_buf_pkg;

  // Default bit period: 100 MHz / 115200 baud.
  localparam int unsigned UART_CLK_PER_BIT = 868;
  localparam int unsigned LEN_BYTE         = 8;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_from_buf_if.sv
// Pop handshake between the byte ring buffer and its consumer.
// master is the consumer that issues orders; slave is the buffer.
interface uart_tx_from_buf_if;

  logic                                       buf_order;
  logic [uart_tx_from_buf_pkg::LEN_BYTE-1:0]  buf_data;
  logic                                       buf_done;

  modport master (
    output buf_order,
    input  buf_data,
    input  buf_done
  );

  modport slave (
    input  buf_order,
    output buf_data,
    output buf_done
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: tick pulses on the last cycle of every CLK_PER_BIT-cycle
// period, counted from the first cycle after restart is released.
module uart_bit_timer #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned LEN_CNT     = $clog2(CLK_PER_BIT)
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam logic [LEN_CNT-1:0] Terminal = LEN_CNT'(CLK_PER_BIT - 1);

  logic [LEN_CNT-1:0] cnt_q;
  logic [LEN_CNT-1:0] cnt_d;

  assign tick = !restart && (cnt_q == Terminal);

  // Next count: hold at zero while restarting, reload on terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_from_buf.sv
// 8N1 UART transmitter that pulls bytes from the ring buffer over the
// order/done pop handshake. All outputs are registered.
module uart_tx_from_buf
  import uart_tx_from_buf_pkg::*;
#(
  parameter int unsigned CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int unsigned LEN_CNT     = $clog2(CLK_PER_BIT)
) (
  input  logic                      clk,
  input  logic                      rstn,
  uart_tx_from_buf_if.master        bus,
  output logic                      txd,
  output logic                      busy
);

  tx_state_e             state_q;
  logic [LEN_BYTE-1:0]   shift_q;
  logic [2:0]            idx_q;
  logic                  order_q;
  logic                  txd_q;
  logic                  busy_q;
  logic                  tick;
  logic                  restart;

  // The timer only runs while a frame is on the wire, so it is aligned to
  // the first cycle of the start bit.
  assign restart = (state_q == StIdle) || (state_q == StReq) || (state_q == StWait);

  uart_bit_timer #(
    .CLK_PER_BIT (CLK_PER_BIT),
    .LEN_CNT     (LEN_CNT)
  ) u_bit_timer (
    .clk     (clk),
    .rstn    (rstn),
    .restart (restart),
    .tick    (tick)
  );

  assign bus.buf_order = order_q;
  assign txd           = txd_q;
  assign busy          = busy_q;

  // Pop/frame FSM with shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      order_q <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      order_q <= 1'b0;
      case (state_q)
        StIdle: begin
          state_q <= StReq;
          order_q <= 1'b1;
        end
        StReq: begin
          state_q <= StWait;
        end
        StWait: begin
          // An empty buffer leaves buf_done low; go round again via IDLE.
          if (bus.buf_done) begin
            shift_q <= bus.buf_data;
            state_q <= StStart;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            idx_q   <= '0;
            txd_q   <= shift_q[0];
          end
        end
        StData: begin
          if (tick) begin
            if (idx_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + 3'd1;
              txd_q   <= shift_q[1];
            end
          end
        end
        StStop: begin
          // Straight back to REQ so back-to-back bytes cost only two idle cycles.
          if (tick) begin
            state_q <= StReq;
            order_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
